spi_bus_port: RTL

- Memory-mapped SPI master port on the 16-bit data BUS.
- Driven by the SPIAddrIn, SPIDWrite and SPIDRead control-word bits from the instruction decoder.
- Consumes BUS words to select a slave and transmit. Holds the received word so a Block16 tri-state gate can return it to BUS.
- Serialises one 16-bit word per transfer, SPI mode 0, MSB first.

---
 rtl/spi_bus_port.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/spi_bus_port.sv
// spi_bus_port: memory-mapped SPI master (mode 0, MSB first, 16-bit words).
// AddrIn latches the slave select, DWrite starts a transfer, DRead acknowledges
// the received word. Optional macro SPI_PORT_LOOPBACK_EN adds a LoopEn input
// that feeds MOSI back into the receive shifter instead of MISO.
module spi_bus_port #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned NUM_CS  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [15:0]       BusIn,
  input  logic              AddrIn,
  input  logic              DWrite,
  input  logic              DRead,
  output logic [15:0]       DOut,
  output logic              Busy,
  output logic              RxValid,
  output logic              Overrun,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
`ifdef SPI_PORT_LOOPBACK_EN
  input  logic              LoopEn,
`endif
  output logic [NUM_CS-1:0] CS_N
);

  localparam int unsigned SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, DONE} state_t;

  state_t             state;
  logic [SEL_W-1:0]   sel;
  logic [SEL_W-1:0]   sel_next;
  logic [NUM_CS-1:0]  cs_next;
  logic [15:0]        tx_sh;
  logic [15:0]        rx_sh;
  logic [15:0]        rx_reg;
  logic [7:0]         div;
  logic [4:0]         bit_cnt;
  logic               tick;
  logic               sample;

  assign DOut = rx_reg;
  assign tick = (div == 8'(CLK_DIV - 1));

`ifdef SPI_PORT_LOOPBACK_EN
  assign sample = LoopEn ? MOSI : MISO;
`else
  assign sample = MISO;
`endif

  // Select used by a transfer starting now: a same-cycle AddrIn takes effect.
  // Out-of-range selects match no line, so every CS_N stays high.
  always_comb begin
    sel_next = AddrIn ? BusIn[SEL_W-1:0] : sel;
    cs_next  = '1;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (sel_next == SEL_W'(i)) cs_next[i] = 1'b0;
    end
  end

  // Transfer state machine; all SPI pins and status flags are registered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      sel     <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_reg  <= '0;
      div     <= '0;
      bit_cnt <= '0;
      Busy    <= 1'b0;
      RxValid <= 1'b0;
      Overrun <= 1'b0;
      SCLK    <= 1'b0;
      MOSI    <= 1'b0;
      CS_N    <= '1;
    end else begin
      // DRead clear is placed first so a DONE set later in this block wins.
      if (DRead) RxValid <= 1'b0;
      if (DWrite && state != IDLE) Overrun <= 1'b1;

      case (state)
        IDLE: begin
          SCLK <= 1'b0;
          if (AddrIn) sel <= BusIn[SEL_W-1:0];
          if (DWrite) begin
            tx_sh <= BusIn;
            MOSI  <= BusIn[15];
            CS_N  <= cs_next;
            Busy  <= 1'b1;
            div   <= '0;
            state <= LEAD;
          end
        end
        LEAD: begin
          if (tick) begin
            div     <= '0;
            bit_cnt <= '0;
            state   <= SHIFT;
          end else begin
            div <= div + 8'd1;
          end
        end
        SHIFT: begin
          if (tick) begin
            div <= '0;
            if (!SCLK) begin
              SCLK  <= 1'b1;
              rx_sh <= {rx_sh[14:0], sample};
            end else begin
              SCLK    <= 1'b0;
              tx_sh   <= {tx_sh[14:0], 1'b0};
              MOSI    <= tx_sh[14];
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd15) state <= TRAIL;
            end
          end else begin
            div <= div + 8'd1;
          end
        end
        TRAIL: begin
          if (tick) begin
            div   <= '0;
            state <= DONE;
          end else begin
            div <= div + 8'd1;
          end
        end
        DONE: begin
          CS_N    <= '1;
          MOSI    <= 1'b0;
          rx_reg  <= rx_sh;
          RxValid <= 1'b1;
          Busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
